// File: rtl/wired_cdb_arbiter_pkg.sv
// wired0_defines: shared definitions for the CDB arbiter slice.
//   - requester index constants (ALU0, ALU1, LSU, MDU) and requester count
//   - default ROB id / result word widths and their typedefs
//   - cdb_req_t: one broadcast payload {rid, data}
package wired0_defines;

    localparam int unsigned CDB_RID_W   = 32'd6;
    localparam int unsigned CDB_DATA_W  = 32'd32;
    localparam int unsigned CDB_CNT_W   = 32'd4;

    localparam int unsigned CDB_REQ_ALU0 = 32'd0;
    localparam int unsigned CDB_REQ_ALU1 = 32'd1;
    localparam int unsigned CDB_REQ_LSU  = 32'd2;
    localparam int unsigned CDB_REQ_MDU  = 32'd3;
    localparam int unsigned CDB_REQ_CNT  = 32'd4;

    typedef logic [CDB_RID_W-1:0]  rob_rid_t;
    typedef logic [CDB_DATA_W-1:0] word_t;

    typedef struct packed {
        rob_rid_t rid;
        word_t    data;
    } cdb_req_t;

endpackage

// File: rtl/wired_cdb_bank_sel.sv
// wired_cdb_bank_sel: pure priority picker for one CDB bank.
// Ports:
//   cand  - requesters targeting this bank with a valid request
//   promo - requesters whose starvation counter has reached the limit
//   grant - one-hot grant (all zero when there is no candidate)
// A promoted LSU beats a promoted MDU, and either beats the default order
// ALU0 > ALU1 > LSU > MDU.
module wired_cdb_bank_sel
    import wired0_defines::*;
(
    input  logic [CDB_REQ_CNT-1:0] cand,
    input  logic [CDB_REQ_CNT-1:0] promo,
    output logic [CDB_REQ_CNT-1:0] grant
);

    // Priority selection with starvation escape ahead of the fixed order.
    always_comb begin
        grant = 4'b0000;
        if (cand[CDB_REQ_LSU] && promo[CDB_REQ_LSU]) begin
            grant[CDB_REQ_LSU] = 1'b1;
        end else if (cand[CDB_REQ_MDU] && promo[CDB_REQ_MDU]) begin
            grant[CDB_REQ_MDU] = 1'b1;
        end else if (cand[CDB_REQ_ALU0]) begin
            grant[CDB_REQ_ALU0] = 1'b1;
        end else if (cand[CDB_REQ_ALU1]) begin
            grant[CDB_REQ_ALU1] = 1'b1;
        end else if (cand[CDB_REQ_LSU]) begin
            grant[CDB_REQ_LSU] = 1'b1;
        end else if (cand[CDB_REQ_MDU]) begin
            grant[CDB_REQ_MDU] = 1'b1;
        end else begin
            grant = 4'b0000;
        end
    end

endmodule

// File: rtl/wired_cdb_arbiter.sv
// wired_cdb_arbiter: shares the two CDB ports between ALU0, ALU1, LSU, MDU.
// CDB port b only ever carries ROB ids with rid[0]==b, so each port writes a
// single ROB bank and the two banks are arbitrated independently.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   req_valid_i  - request per requester (0=ALU0 1=ALU1 2=LSU 3=MDU)
//   req_rid_i    - target ROB id per requester
//   req_data_i   - result word per requester
//   req_ready_o  - combinational grant; transfer on valid & ready
//   flush_i      - backend flush: no grants, counters cleared
//   cdb_valid_o  - registered broadcast valid per port (1 cycle after grant)
//   cdb_rid_o    - registered broadcast ROB id per port
//   cdb_data_o   - registered broadcast data per port
module wired_cdb_arbiter
    import wired0_defines::*;
#(
    parameter int unsigned RID_WIDTH    = CDB_RID_W,
    parameter int unsigned DATA_WIDTH   = CDB_DATA_W,
    parameter int unsigned STARVE_LIMIT = 32'd4
)(
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [CDB_REQ_CNT-1:0]                 req_valid_i,
    input  logic [CDB_REQ_CNT-1:0][RID_WIDTH-1:0]  req_rid_i,
    input  logic [CDB_REQ_CNT-1:0][DATA_WIDTH-1:0] req_data_i,
    output logic [CDB_REQ_CNT-1:0]                 req_ready_o,
    input  logic                                   flush_i,
    output logic [1:0]                             cdb_valid_o,
    output logic [1:0][RID_WIDTH-1:0]              cdb_rid_o,
    output logic [1:0][DATA_WIDTH-1:0]             cdb_data_o
);

    localparam logic [CDB_CNT_W-1:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [1:0][CDB_REQ_CNT-1:0] cand_s;
    logic [1:0][CDB_REQ_CNT-1:0] grant_s;
    logic [CDB_REQ_CNT-1:0]      promo_s;
    logic [CDB_REQ_CNT-1:0]      grant_any_s;
    logic [CDB_CNT_W-1:0]        lsu_cnt_r;
    logic [CDB_CNT_W-1:0]        mdu_cnt_r;
    logic [1:0][RID_WIDTH-1:0]   win_rid_s;
    logic [1:0][DATA_WIDTH-1:0]  win_data_s;

    // Next starvation count: clear on grant, idle or flush, else saturate up.
    function automatic logic [CDB_CNT_W-1:0] next_cnt(
        input logic [CDB_CNT_W-1:0] cnt,
        input logic                 valid,
        input logic                 granted,
        input logic                 flush
    );
        logic [CDB_CNT_W-1:0] nxt;
        if (flush || !valid || granted) begin
            nxt = 4'd0;
        end else if (cnt >= LIMIT_C) begin
            nxt = LIMIT_C;
        end else begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

    // Bank steering; reset and flush suppress every candidate, hence every grant.
    always_comb begin
        cand_s = '0;
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < CDB_REQ_CNT; r++) begin
                cand_s[b][r] = rst_n && !flush_i && req_valid_i[r]
                               && (req_rid_i[r][0] == 1'(b));
            end
        end
    end

    // Promotion mask; only LSU and MDU can be promoted.
    always_comb begin
        promo_s              = 4'b0000;
        promo_s[CDB_REQ_LSU] = (lsu_cnt_r == LIMIT_C);
        promo_s[CDB_REQ_MDU] = (mdu_cnt_r == LIMIT_C);
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        wired_cdb_bank_sel u_sel (
            .cand  (cand_s[b]),
            .promo (promo_s),
            .grant (grant_s[b])
        );
    end

    assign grant_any_s = grant_s[0] | grant_s[1];
    assign req_ready_o = grant_any_s;

    // Winner payload per bank; grants are one-hot so an AND-OR mux suffices.
    always_comb begin
        win_rid_s  = '0;
        win_data_s = '0;
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < CDB_REQ_CNT; r++) begin
                win_rid_s[b]  = win_rid_s[b]  | (req_rid_i[r]  & {RID_WIDTH{grant_s[b][r]}});
                win_data_s[b] = win_data_s[b] | (req_data_i[r] & {DATA_WIDTH{grant_s[b][r]}});
            end
        end
    end

    // Starvation counters for LSU and MDU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsu_cnt_r <= 4'd0;
            mdu_cnt_r <= 4'd0;
        end else begin
            lsu_cnt_r <= next_cnt(lsu_cnt_r, req_valid_i[CDB_REQ_LSU],
                                  grant_any_s[CDB_REQ_LSU], flush_i);
            mdu_cnt_r <= next_cnt(mdu_cnt_r, req_valid_i[CDB_REQ_MDU],
                                  grant_any_s[CDB_REQ_MDU], flush_i);
        end
    end

    // CDB output register; payload holds when the bank has no grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_o <= 2'b00;
            cdb_rid_o   <= '0;
            cdb_data_o  <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                cdb_valid_o[b] <= (|grant_s[b]) && !flush_i;
                if (|grant_s[b]) begin
                    cdb_rid_o[b]  <= win_rid_s[b];
                    cdb_data_o[b] <= win_data_s[b];
                end else begin
                    cdb_rid_o[b]  <= cdb_rid_o[b];
                    cdb_data_o[b] <= cdb_data_o[b];
                end
            end
        end
    end

endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// Scoreboard bench for wired_cdb_arbiter: stimulus pushes expected broadcasts
// into per-port queues, a monitor pops them one cycle later.
module tb_wired_cdb_arbiter;
    import wired0_defines::*;

    localparam int LIMIT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0][5:0]  req_rid;
    logic [3:0][31:0] req_data;
    logic [3:0]       req_ready;
    logic             flush;
    logic [1:0]       cdb_valid;
    logic [1:0][5:0]  cdb_rid;
    logic [1:0][31:0] cdb_data;

    wired_cdb_arbiter #(.RID_WIDTH(6), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_rid_i(req_rid), .req_data_i(req_data),
        .req_ready_o(req_ready), .flush_i(flush),
        .cdb_valid_o(cdb_valid), .cdb_rid_o(cdb_rid), .cdb_data_o(cdb_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    cdb_req_t q0[$];
    cdb_req_t q1[$];
    int cnt_m[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every valid CDB beat must match the oldest expected entry.
    initial begin
        cdb_req_t e;
        bit has;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1) begin
                for (int b = 0; b < 2; b++) begin
                    has = (b == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    if (has) begin
                        if (b == 0) e = q0.pop_front(); else e = q1.pop_front();
                    end
                    if (cdb_valid[b] === 1'b1) begin
                        if (!has) begin
                            check($sformatf("spurious_valid_p%0d", b), 64'(cdb_valid[b]), 64'd0);
                        end else begin
                            check($sformatf("cdb_rid_p%0d", b), 64'(cdb_rid[b]), 64'(e.rid));
                            check($sformatf("cdb_data_p%0d", b), 64'(cdb_data[b]), 64'(e.data));
                        end
                    end else if (has) begin
                        check($sformatf("missing_valid_p%0d", b), 64'(cdb_valid[b]), 64'd1);
                    end
                end
            end
        end
    end

    // One cycle: drive inputs, predict grants from the priority rules, check ready.
    task automatic step(input logic [3:0] v, input logic [3:0][5:0] rids,
                        input logic [3:0][31:0] d, input logic fl, output logic [3:0] g);
        int order[$];
        bit cand;
        bit lsu_p, mdu_p;
        cdb_req_t e;
        @(negedge clk);
        req_valid = v; req_rid = rids; req_data = d; flush = fl;
        #1;
        g = 4'b0000;
        if (!fl) begin
            for (int b = 0; b < 2; b++) begin
                lsu_p = v[2] && (rids[2][0] == 1'(b)) && (cnt_m[2] == LIMIT);
                mdu_p = v[3] && (rids[3][0] == 1'(b)) && (cnt_m[3] == LIMIT);
                order = {};
                if (lsu_p) order.push_back(2);
                if (mdu_p) order.push_back(3);
                for (int r = 0; r < 4; r++)
                    if (!((r == 2 && lsu_p) || (r == 3 && mdu_p))) order.push_back(r);
                foreach (order[i]) begin
                    cand = v[order[i]] && (rids[order[i]][0] == 1'(b));
                    if (cand) begin
                        g[order[i]] = 1'b1;
                        e.rid = rids[order[i]];
                        e.data = d[order[i]];
                        if (b == 0) q0.push_back(e); else q1.push_back(e);
                        break;
                    end
                end
            end
        end
        check("req_ready", 64'(req_ready), 64'(g));
        for (int r = 2; r < 4; r++) begin
            if (fl || !v[r] || g[r]) cnt_m[r] = 0;
            else if (cnt_m[r] < LIMIT) cnt_m[r]++;
        end
    endtask

    logic [3:0]       v, g, pv;
    logic [3:0][5:0]  rr, prid;
    logic [3:0][31:0] dd, pdata;
    logic             fl;
    int               hit;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_rid = '0; req_data = '0; flush = 1'b0;
        foreach (cnt_m[i]) cnt_m[i] = 0;
        #2;
        check("reset_valid", 64'(cdb_valid), 64'd0);
        check("reset_rid", 64'(cdb_rid), 64'd0);
        check("reset_data", 64'(cdb_data), 64'd0);
        check("reset_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rr = '0; dd = '0;
        step('0, rr, dd, 1'b0, g);

        // Bank split
        v = 4'b0011; rr = '0; dd = '0;
        rr[0] = 6'h04; dd[0] = 32'hAAAA_0001;
        rr[1] = 6'h07; dd[1] = 32'hBBBB_0002;
        step(v, rr, dd, 1'b0, g);
        check("split_ready", 64'(req_ready), 64'h3);
        step('0, rr, dd, 1'b0, g);

        // Same-bank conflict drains in priority order
        v = 4'b1111;
        rr[0] = 6'h02; rr[1] = 6'h04; rr[2] = 6'h06; rr[3] = 6'h08;
        dd[0] = 32'h1111_0000; dd[1] = 32'h2222_0000; dd[2] = 32'h3333_0000; dd[3] = 32'h4444_0000;
        for (int i = 0; i < 4; i++) begin
            step(v, rr, dd, 1'b0, g);
            check($sformatf("conflict_order_%0d", i), 64'(req_ready), 64'(4'b0001 << i));
            v = v & ~g;
        end
        step('0, rr, dd, 1'b0, g);

        // Starvation: MDU promoted on the 5th cycle
        v = 4'b1001; rr = '0; dd = '0; rr[3] = 6'h10; dd[3] = 32'hDEAD_0010;
        for (int c = 1; c <= 6; c++) begin
            rr[0] = 6'(20 + 2 * c); dd[0] = 32'(c);
            step(v, rr, dd, 1'b0, g);
            if (c == 5) check("starve_mdu_wins", 64'(req_ready), 64'h8);
            else check($sformatf("starve_alu0_c%0d", c), 64'(req_ready), 64'h1);
            v = v & ~g;
            v[0] = 1'b1;
        end
        step('0, rr, dd, 1'b0, g);

        // Flush: no grant, no broadcast
        v = 4'b0100; rr = '0; rr[2] = 6'h03; dd = '0; dd[2] = 32'h0F0F_0003;
        step(v, rr, dd, 1'b1, g);
        check("flush_ready", 64'(req_ready), 64'd0);
        step('0, rr, dd, 1'b0, g);

        // Flush clears a partially built MDU counter
        v = 4'b1001; rr = '0; rr[3] = 6'h12; dd = '0;
        for (int c = 0; c < 3; c++) begin
            rr[0] = 6'(2 * c); step(v, rr, dd, 1'b0, g);
        end
        step(v, rr, dd, 1'b1, g);
        hit = 0;
        for (int c = 1; c <= 8 && hit == 0; c++) begin
            rr[0] = 6'(40 + 2 * c); step(v, rr, dd, 1'b0, g);
            if (req_ready[3] === 1'b1) hit = c;
            v = v & ~g; v[0] = 1'b1;
        end
        check("flush_cnt_cleared", 64'(hit), 64'd5);
        step('0, rr, dd, 1'b0, g);

        // Back-to-back on bank 1
        v = 4'b0010; rr = '0; dd = '0;
        for (int i = 0; i < 8; i++) begin
            rr[1] = 6'(2 * i + 1); dd[1] = $urandom;
            step(v, rr, dd, 1'b0, g);
        end
        step('0, rr, dd, 1'b0, g);

        // Reset mid-transfer
        v = 4'b0001; rr = '0; rr[0] = 6'h0A; dd = '0; dd[0] = 32'hCAFE_000A;
        step(v, rr, dd, 1'b0, g);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midreset_valid", 64'(cdb_valid), 64'd0);
        check("midreset_ready", 64'(req_ready), 64'd0);
        q0.delete(); q1.delete();
        foreach (cnt_m[i]) cnt_m[i] = 0;
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step('0, rr, dd, 1'b0, g);

        // Randomized traffic honouring the hold-until-granted rule
        pv = '0; prid = '0; pdata = '0;
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 4; r++) begin
                if (!pv[r] && ($urandom_range(0, 1) == 1)) begin
                    pv[r] = 1'b1;
                    prid[r] = (6'($urandom_range(0, 63)) & 6'h3E) | 6'($urandom_range(0, 3) == 0);
                    pdata[r] = $urandom;
                end
            end
            fl = ($urandom_range(0, 19) == 0);
            step(pv, prid, pdata, fl, g);
            pv = pv & ~g;
            if (fl) for (int r = 0; r < 4; r++) if ($urandom_range(0, 1) == 1) pv[r] = 1'b0;
        end
        step('0, rr, dd, 1'b0, g);
        step('0, rr, dd, 1'b0, g);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wired_cdb_arbiter.md
Name: wired_cdb_arbiter

Overview:
- Shares the two CDB broadcast ports between the result producers: ALU lane 0, ALU lane 1, LSU and MDU.
- CDB port b writes ROB bank b only, where b = rid[0]. This removes ROB bank conflicts by construction.
- Arbitration is fixed priority ALU0 > ALU1 > LSU > MDU per bank, with a starvation escape for LSU and MDU.
- Output is registered: the result appears on the CDB 1 cycle after grant. The block sits between the FU issue queues and the CDB snoop and ROB write fan-out.

Parameters:
- RID_WIDTH, 6, width of the ROB id; bit 0 selects the ROB bank.
- DATA_WIDTH, 32, width of the result word.
- STARVE_LIMIT, 4, consecutive lost cycles after which LSU or MDU is promoted to top priority; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  4  request per requester; index 0=ALU0, 1=ALU1, 2=LSU, 3=MDU.
- req_rid_i  in  4xRID_WIDTH  target ROB id per requester.
- req_data_i  in  4xDATA_WIDTH  result word per requester.
- req_ready_o  out  4  grant; the transfer completes when valid and ready are both high.
- flush_i  in  1  backend flush.
- cdb_valid_o  out  2  CDB port valid; port b carries only rids with rid[0]==b.
- cdb_rid_o  out  2xRID_WIDTH  broadcast ROB id.
- cdb_data_o  out  2xDATA_WIDTH  broadcast data.

Behaviour:
- Reset (async, rst_n low):
  - cdb_valid_o=0, cdb_rid_o=0, cdb_data_o=0.
  - Starvation counters=0.
  - req_ready_o is combinational and is 0 while rst_n is low.
- Bank steering: requester r is a candidate for bank b when req_valid_i[r] and req_rid_i[r][0]==b.
- Per-bank grant, evaluated independently for each bank:
  - At most one grant per bank, so at most two grants per cycle.
  - Default priority is ALU0 > ALU1 > LSU > MDU.
  - Starvation promotion: a requester is promoted if its counter equals STARVE_LIMIT and it is a candidate. A promoted requester outranks everything in its bank.
  - If both LSU and MDU are promoted in the same bank, LSU wins.
- req_ready_o:
  - It is the grant, combinational from the valids, rids and counters. Ready may depend on valid.
  - Requesters hold rid and data stable while valid is high and ready is low.
  - Once asserted, valid must not drop until the grant occurs, except when flush_i is high.
- CDB has no back-pressure. Broadcast is unconditional.
- Output register:
  - On clock, cdb_valid_o[b] <= (grant exists for bank b) and !flush_i.
  - rid and data load from the granted requester. They hold their old value when there is no grant.
  - Latency is exactly 1 cycle from handshake to CDB. A port is valid for exactly 1 cycle per transfer.
- Starvation counters (LSU and MDU only, 4-bit, saturating at STARVE_LIMIT):
  - Increment when the requester is valid and not granted.
  - Clear on grant, when valid is low, or when flush_i is high.
- Flush:
  - While flush_i is high, req_ready_o=0.
  - Next cycle cdb_valid_o=0 and counters=0.
  - A transfer registered in the cycle before flush_i is raised still broadcasts in the flush cycle; the ROB discards it.
- Simultaneous events:
  - All four requesters targeting the same bank produce one grant per cycle. Worst-case drain is 4 cycles, and priority order holds absent starvation.
  - A promotion and a higher-priority newcomer in the same cycle resolve in favour of the promoted requester.
- Counter never exceeds STARVE_LIMIT. With STARVE_LIMIT=1, promotion occurs after one lost cycle.

Decomposition:
- Shared package wired0_defines:
  - Requester index constants CDB_REQ_ALU0, CDB_REQ_ALU1, CDB_REQ_LSU, CDB_REQ_MDU.
  - Constant CDB_REQ_CNT=4.
  - Typedef cdb_req_t {rid, data}, reusing rob_rid_t and word_t.
- Sub-module wired_cdb_bank_sel, instantiated once per bank:
  - Inputs: the candidate mask and promotion mask.
  - Output: a one-hot grant.
  - Pure priority logic.
- The parent holds the counters and the output register.

Test Plan:
- Reset: rst_n low mid-transfer → cdb_valid_o=2'b00 immediately. After release, no spurious valid until a request arrives.
- Bank split:
  - Stimulus: ALU0 rid=6'h04 data=32'hAAAA_0001; ALU1 rid=6'h07 data=32'hBBBB_0002; same cycle.
  - Required: both ready=1; next cycle port0={04,AAAA_0001} and port1={07,BBBB_0002}.
- Same-bank conflict:
  - Stimulus: ALU0, ALU1, LSU, MDU all request with even rids 02, 04, 06, 08.
  - Required: grants in order ALU0, ALU1, LSU, MDU over 4 cycles; port0 valid on 4 consecutive cycles; port1 stays 0.
- Starvation (STARVE_LIMIT=4):
  - Stimulus: ALU0 requests bank0 continuously with new rids; MDU holds rid=6'h10 valid.
  - Required: MDU ready=1 in cycle 5; its counter clears; ALU0 wins again in cycle 6.
- Flush:
  - Stimulus: LSU rid=6'h03 valid; flush_i=1 in the same cycle.
  - Required: req_ready_o=0; next cycle cdb_valid_o=0; MDU and LSU counters=0.
- Back-to-back: ALU1 issues a new rid every cycle on bank1 → port1 valid every cycle with a 1-cycle lag and no bubbles.
